// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick responder: FSM state encoding
// and the default number of bits carried per player.
package joy_db15_pkg;

    localparam int P_BITS_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } joy_state_e;

endpackage

// File: rtl/joy_db15_responder_sync_edge.sv
// Two-flop synchronizer for a strobe from the reader, followed by a
// previous-value register that yields single-cycle rise and fall pulses.
// All flops reset to 1 so an idle-high strobe never produces a fake edge.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Bring the asynchronous strobe into the clk domain and remember its last value
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/joy_db15_responder.sv
// Responder end of the DB15 serial joystick link: latches both players'
// controls on the reader's load strobe and shifts them out, player 1 bit 0
// first, on each rising edge of the reader's shift clock. Pressed is 0 on
// the wire and the line idles high.
module joy_db15_responder
    import joy_db15_pkg::*;
#(
    parameter  int P_BITS     = P_BITS_DEFAULT,
    localparam int FRAME_BITS = 2 * P_BITS,
    localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P_BITS-1:0] joystick1,
    input  logic [P_BITS-1:0] joystick2,
    input  logic              joy_load,
    input  logic              joy_clk,
    output logic              joy_data,
    output logic              frame_done,
    output logic              short_frame,
    output logic [CNT_W-1:0]  bit_cnt
);

    joy_state_e            state;
    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] load_image;
    logic                  load_rise;
    logic                  load_fall;
    logic                  clk_rise;
    logic                  unused_clk_fall;

    sync_edge u_load_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (joy_load),
        .rise     (load_rise),
        .fall     (load_fall)
    );

    sync_edge u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (joy_clk),
        .rise     (clk_rise),
        .fall     (unused_clk_fall)
    );

    assign load_image = {~joystick2, ~joystick1};
    assign joy_data   = sr[0];

    // Frame FSM: load transparently while the strobe is low, then shift one bit per reader clock edge.
    // The synchronizer resets high, so after reset any low level on joy_load shows up as a fall,
    // which is what moves IDLE into LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '1;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_fall) begin
                        state   <= LOAD;
                        sr      <= load_image;
                        bit_cnt <= '0;
                    end
                end
                LOAD: begin
                    sr      <= load_image;
                    bit_cnt <= '0;
                    if (load_rise) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load_fall) begin
                        state       <= LOAD;
                        sr          <= load_image;
                        bit_cnt     <= '0;
                        short_frame <= (bit_cnt != '0);
                    end else if (clk_rise) begin
                        sr      <= {1'b1, sr[FRAME_BITS-1:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load_fall) begin
                        state   <= LOAD;
                        sr      <= load_image;
                        bit_cnt <= '0;
                    end else if (clk_rise) begin
                        sr <= {1'b1, sr[FRAME_BITS-1:1]};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed bench for joy_db15_responder acting as a DB15 reader: drives
// load/clock strobes with 8-cycle phases, predicts the serial stream from
// the joystick words and scores each sampled bit against a queue.
module tb_joy_db15_responder;

    localparam int P_BITS     = 12;
    localparam int FRAME_BITS = 2 * P_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int PHASE      = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [P_BITS-1:0] joystick1;
    logic [P_BITS-1:0] joystick2;
    logic              joy_load;
    logic              joy_clk;
    logic              joy_data;
    logic              frame_done;
    logic              short_frame;
    logic [CNT_W-1:0]  bit_cnt;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    int shortCount  = 0;
    int modelShifts = 0;
    logic expQ[$];

    joy_db15_responder #(.P_BITS(P_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .joy_load    (joy_load),
        .joy_clk     (joy_clk),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .bit_cnt     (bit_cnt)
    );

    // 100 MHz-style bench clock; only relative cycle counts matter here
    always #5 clk = ~clk;

    // Count the one-cycle status pulses away from the active edge
    always @(negedge clk) begin
        if (frame_done)  doneCount++;
        if (short_frame) shortCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [P_BITS-1:0] j1, input logic [P_BITS-1:0] j2);
        joystick1 = j1;
        joystick2 = j2;
    endtask

    task automatic sampleBit(input string tag);
        logic expBit;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            expBit = expQ.pop_front();
            checkOutput(tag, {31'd0, joy_data}, {31'd0, expBit});
        end
    endtask

    // Pulse load low then high; the predicted frame is queued when the load is driven
    task automatic loadFrame(input string tag);
        logic [FRAME_BITS-1:0] image;
        image = {~joystick2, ~joystick1};
        expQ.delete();
        modelShifts = 0;
        for (int i = 0; i < FRAME_BITS; i++) expQ.push_back(image[i]);
        joy_load = 1'b0;
        waitCycles(PHASE);
        joy_load = 1'b1;
        waitCycles(PHASE);
        checkOutput({tag, "_cnt_after_load"}, 32'(bit_cnt), 32'd0);
        sampleBit({tag, "_bit0"});
    endtask

    // One reader clock pulse, sampling data and counter late in the high phase
    task automatic shiftClock(input string tag);
        joy_clk = 1'b1;
        modelShifts++;
        if (modelShifts >= FRAME_BITS) expQ.push_back(1'b1);
        waitCycles(PHASE);
        sampleBit($sformatf("%s_shift%0d", tag, modelShifts));
        checkOutput($sformatf("%s_cnt%0d", tag, modelShifts), 32'(bit_cnt),
                    (modelShifts > FRAME_BITS) ? FRAME_BITS : modelShifts);
        joy_clk = 1'b0;
        waitCycles(PHASE);
    endtask

    initial begin
        reset    = 1'b1;
        joy_load = 1'b1;
        joy_clk  = 1'b0;
        applyStimulus('0, '0);
        waitCycles(4);
        checkOutput("reset_data", {31'd0, joy_data}, 32'd1);
        checkOutput("reset_cnt", 32'(bit_cnt), 32'd0);
        reset = 1'b0;

        // Idle line with no strobes
        waitCycles(100);
        checkOutput("idle_data", {31'd0, joy_data}, 32'd1);
        checkOutput("idle_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("idle_done", doneCount, 32'd0);
        checkOutput("idle_short", shortCount, 32'd0);

        // Full frame with only the first and last bits pressed, then two extra clocks
        applyStimulus(12'h001, 12'h800);
        loadFrame("edge");
        for (int i = 0; i < FRAME_BITS - 1; i++) shiftClock("edge");
        checkOutput("edge_no_early_done", doneCount, 32'd0);
        shiftClock("edge");
        checkOutput("edge_done", doneCount, 32'd1);
        shiftClock("edge");
        shiftClock("edge");
        checkOutput("edge_single_done", doneCount, 32'd1);

        // Interrupted frame followed by a complete one
        applyStimulus(12'h5A3, 12'h1C7);
        loadFrame("part");
        for (int i = 0; i < 10; i++) shiftClock("part");
        checkOutput("part_no_short_yet", shortCount, 32'd0);
        loadFrame("after_short");
        checkOutput("short_pulse", shortCount, 32'd1);
        for (int i = 0; i < FRAME_BITS; i++) shiftClock("after_short");
        checkOutput("after_short_done", doneCount, 32'd2);
        checkOutput("after_short_single", shortCount, 32'd1);

        // Inputs changing mid-frame only affect the next frame
        applyStimulus(12'h000, 12'h000);
        loadFrame("hold");
        for (int i = 0; i < 3; i++) shiftClock("hold");
        applyStimulus(12'hFFF, 12'h000);
        for (int i = 3; i < FRAME_BITS; i++) shiftClock("hold");
        loadFrame("next");
        for (int i = 0; i < FRAME_BITS; i++) shiftClock("next");
        checkOutput("next_done", doneCount, 32'd4);
        checkOutput("done_load_no_short", shortCount, 32'd1);

        // Reset in the middle of a frame, then a clean frame
        applyStimulus(12'hA5A, 12'h3C6);
        loadFrame("pre_reset");
        for (int i = 0; i < 5; i++) shiftClock("pre_reset");
        reset = 1'b1;
        waitCycles(2);
        checkOutput("mid_reset_data", {31'd0, joy_data}, 32'd1);
        checkOutput("mid_reset_cnt", 32'(bit_cnt), 32'd0);
        reset = 1'b0;
        waitCycles(10);
        checkOutput("post_reset_idle_data", {31'd0, joy_data}, 32'd1);
        loadFrame("post_reset");
        for (int i = 0; i < FRAME_BITS; i++) shiftClock("post_reset");
        checkOutput("post_reset_done", doneCount, 32'd5);
        checkOutput("post_reset_short", shortCount, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/joy_db15_responder.md
# joy_db15_responder

Clocked model of the external DB15 joystick adapter: two 12-bit parallel-in/serial-out shift stages that answer the `JOY_LOAD`/`JOY_CLK` strobes by driving `JOY_DATA`. It is the responder end of the DB15 serial joystick link. It sits behind the user port, either as a bench model for the DB15 reader or as a joystick emulator feeding a second core. Inputs are button/direction words; output is the serial bit stream the reader expects.

## Interface
Parameters:
- `P_BITS`, default 12: bits per player (legal 4..16).
- `FRAME_BITS`, default 2*P_BITS: derived localparam, bits per frame.
- `CNT_W`, default $clog2(FRAME_BITS+1): derived localparam, bit counter width.

Ports:
- `clk`  in  1  single clock, 40–50 MHz
- `reset`  in  1  synchronous, active-high
- `joystick1`  in  P_BITS  player 1 controls, 1 = pressed
- `joystick2`  in  P_BITS  player 2 controls, 1 = pressed
- `joy_load`  in  1  parallel-load strobe from reader, active-low, asynchronous to `clk`
- `joy_clk`  in  1  shift clock from reader, rising edge shifts, asynchronous to `clk`
- `joy_data`  out  1  serial data to reader, active-low buttons, idles 1
- `frame_done`  out  1  one-cycle pulse when the last frame bit has been shifted out
- `short_frame`  out  1  one-cycle pulse when a load interrupts a partial frame
- `bit_cnt`  out  CNT_W  shifts completed in current frame

## Operation
- `joy_load` and `joy_clk` each pass through a 2-FF synchronizer, then a registered previous-value edge detector.
- Shift register `sr[FRAME_BITS-1:0]`: `joy_data = sr[0]`. On wire, pressed = 0.
- Load image is `{~joystick2, ~joystick1}`, so `joystick1[0]` goes out first and `joystick2[P_BITS-1]` goes out last.
- Serial-in is tied to 1: each shift does `sr <= {1'b1, sr[FRAME_BITS-1:1]}`.

States:
- **IDLE**: after reset. Data is 1 and shift edges are ignored. Synchronized load low → LOAD.
- **LOAD**: `sr` reloads from the inputs every cycle, so the panel is transparent like a '165 with PL low. `bit_cnt` = 0 and shift edges are ignored. Synchronized load rising → SHIFT.
- **SHIFT**: each `joy_clk` rising edge shifts and increments `bit_cnt`. When `bit_cnt` reaches FRAME_BITS → DONE, with a `frame_done` pulse in the same cycle. Load falling edge → LOAD; if `bit_cnt` ≥ 1, pulse `short_frame`.
- **DONE**: further clock edges keep shifting 1s in. `bit_cnt` saturates at FRAME_BITS. Load falling edge → LOAD with no `short_frame`.

Boundary rules:
- Load falling and clock rising in the same cycle: load wins, no shift.
- Load rising and clock rising in the same cycle: no shift. The first shift needs a clock edge strictly after load goes high.
- Input words are sampled only in LOAD. Changes during SHIFT or DONE affect the next frame only.
- `reset` mid-frame: everything returns to reset values the next cycle, regardless of state or strobe levels.
- Reset values: state IDLE, `sr` all 1s, `joy_data` 1, `bit_cnt` 0, `frame_done` 0, `short_frame` 0.

## Timing
- Pin edge to synchronized level: 2 cycles. Edge detect plus `sr`/state update lands on the 3rd `clk` edge.
- `joy_data` changes exactly 3 cycles after a `joy_clk` rise, or after a `joy_load` fall in LOAD.
- `frame_done` and `short_frame` assert in the same cycle as the corresponding state transition.
- Reader requirement: `joy_clk` and `joy_load` high and low phases each ≥ 4 `clk` cycles. The reader samples `joy_data` ≥ 4 cycles after its own edge.
- The design is fully registered. There is no combinational path from inputs to outputs.

## Structure
- Package `joy_db15_pkg`: state enum `{IDLE, LOAD, SHIFT, DONE}` and default `P_BITS` constant.
- Sub-module `sync_edge` (2-FF synchronizer, rise and fall pulses, reset to 1), instantiated for `joy_load` and `joy_clk`.
- Top module: FSM, shift register and counter.

## Test plan
- Reset, then no strobes for 100 cycles → `joy_data`=1, `bit_cnt`=0, no pulses.
- `joystick1`=12'h001, `joystick2`=12'h800, full load plus 24 clocks (8-cycle phases) → serial bits 0,1×22,0; `frame_done` on shift 24; `bit_cnt`=24.
- Same frame with a 25th and 26th clock → `joy_data` stays 1, `bit_cnt` holds 24, no second `frame_done`.
- Load after 10 shifts → `short_frame` pulses once; the next full frame is correct.
- Change `joystick1` from 12'h000 to 12'hFFF during SHIFT → the current frame still shows all 1s for P1; the next frame shows 12 zeros.
- Assert `reset` at shift 5, release, then do a full frame → state IDLE and `joy_data`=1 during reset; the following frame is bit-exact.
